// File: rtl/instr_packer_if.sv
// Field-bundle input handshake plus instruction-memory write port of the packer.
interface instr_packer_if #(
   parameter int unsigned CNT_W = 11
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       fmt;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [4:0]       shamt;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic [15:0]      immediate;
   logic [25:0]      instr_index;
   logic             im_we;
   logic             im_ready;
   logic [31:0]      im_addr;
   logic [31:0]      im_wdata;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             err;

   modport master (
      output in_valid, fmt, opcode, funct, shamt, rs, rt, rd, immediate, instr_index, im_ready,
      input  in_ready, im_we, im_addr, im_wdata, count, full, err
   );

   modport slave (
      input  in_valid, fmt, opcode, funct, shamt, rs, rt, rd, immediate, instr_index, im_ready,
      output in_ready, im_we, im_addr, im_wdata, count, full, err
   );
endinterface

// File: rtl/instr_packer.sv
// Packs decoded MIPS fields into 32-bit words and writes them sequentially into IM.
module instr_packer #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned CNT_W     = 11,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   instr_packer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WRITE, FULL} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      packed_c;
   logic [CNT_W-1:0] cnt_inc_c;
   logic             in_ready_c;

   // Field placement by format; fields unused by a format are ignored.
   always_comb begin
      packed_c = '0;
      case (bus.fmt)
         2'b00:   packed_c = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
         2'b01:   packed_c = {bus.opcode, bus.rs, bus.rt, bus.immediate};
         2'b10:   packed_c = {bus.opcode, bus.instr_index};
         default: packed_c = '0;
      endcase
   end

   assign in_ready_c = (state_q == IDLE) && !clear;
   assign cnt_inc_c  = count_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      err_d   = err_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (clear) begin
         state_d = IDLE;
         count_d = '0;
         err_d   = 1'b0;
         we_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_c) begin
                  if (bus.fmt == 2'b11) begin
                     err_d = 1'b1;
                  end else begin
                     wdata_d = packed_c;
                     addr_d  = BASE_ADDR + 32'({count_q, 2'b00});
                     we_d    = 1'b1;
                     state_d = WRITE;
                  end
               end
            end
            WRITE: begin
               if (bus.im_ready) begin
                  we_d    = 1'b0;
                  count_d = cnt_inc_c;
                  state_d = (cnt_inc_c == CNT_W'(DEPTH)) ? FULL : IDLE;
               end
            end
            FULL:    state_d = FULL;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.im_we    = we_q;
   assign bus.im_addr  = addr_q;
   assign bus.im_wdata = wdata_q;
   assign bus.count    = count_q;
   assign bus.full     = (state_q == FULL);
   assign bus.err      = err_q;

endmodule

// File: tb/tb_instr_packer.sv
// Randomized scoreboard bench for instr_packer built with a 4-word IM.
module tb_instr_packer;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 3;
   localparam logic [31:0] BASE  = 32'h0000_3000;

   logic clk = 1'b0;
   logic reset;
   logic clear;

   instr_packer_if #(.CNT_W(CNT_W)) bus_if ();

   instr_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // Transaction-level reference: pending write queue of {addr, word}, words written, sticky error.
   logic [63:0] exp_q[$];
   int unsigned m_count = 0;
   bit          m_busy  = 0;
   bit          m_err   = 0;
   bit          m_fresh = 1;
   int          n_pass  = 0;
   int          n_total = 0;

   function automatic logic [31:0] ref_pack(input int unsigned f, op, rs, rt, rd, sh, fn, imm, idx);
      int unsigned w;
      case (f)
         0:       w = op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
         1:       w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
         default: w = op * 67108864 + idx;
      endcase
      return w;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
   endtask

   // Advance one clock and apply that edge's effect to the reference model.
   task automatic step();
      @(posedge clk);
      if (!reset) begin
         m_count = 0; m_busy = 0; m_err = 0; m_fresh = 1; exp_q.delete();
      end else if (clear) begin
         m_count = 0; m_busy = 0; m_err = 0; exp_q.delete();
      end else if (m_busy) begin
         if (bus_if.im_ready) begin
            m_busy = 0;
            m_count++;
            void'(exp_q.pop_front());
         end
      end else if (m_count != DEPTH && bus_if.in_valid) begin
         if (bus_if.fmt == 2'b11) begin
            m_err = 1;
         end else begin
            exp_q.push_back({BASE + 4 * m_count,
                             ref_pack(bus_if.fmt, bus_if.opcode, bus_if.rs, bus_if.rt, bus_if.rd,
                                      bus_if.shamt, bus_if.funct, bus_if.immediate, bus_if.instr_index)});
            m_busy  = 1;
            m_fresh = 0;
         end
      end
      #1;
   endtask

   task automatic rand_fields();
      bus_if.fmt         = 2'($urandom_range(0, 2));
      bus_if.opcode      = 6'($urandom);
      bus_if.funct       = 6'($urandom);
      bus_if.shamt       = 5'($urandom);
      bus_if.rs          = 5'($urandom);
      bus_if.rt          = 5'($urandom);
      bus_if.rd          = 5'($urandom);
      bus_if.immediate   = 16'($urandom);
      bus_if.instr_index = 26'($urandom);
   endtask

   task automatic send_one();
      bus_if.in_valid = 1'b1;
      step();
      bus_if.in_valid = 1'b0;
   endtask

   // Monitor: compares DUT outputs against the model on every falling edge.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("im_we", 32'(bus_if.im_we), 32'(m_busy));
         chk("in_ready", 32'(bus_if.in_ready), 32'(!m_busy && m_count != DEPTH && !clear));
         chk("count", 32'(bus_if.count), m_count);
         chk("full", 32'(bus_if.full), 32'(m_count == DEPTH));
         chk("err", 32'(bus_if.err), 32'(m_err));
         if (m_busy && exp_q.size() > 0) begin
            chk("im_addr", bus_if.im_addr, exp_q[0][63:32]);
            chk("im_wdata", bus_if.im_wdata, exp_q[0][31:0]);
         end else if (m_fresh) begin
            chk("im_addr_rst", bus_if.im_addr, BASE);
            chk("im_wdata_rst", bus_if.im_wdata, 32'h0);
         end
      end
   end

   initial begin
      reset = 1'b0; clear = 1'b0;
      bus_if.in_valid = 1'b0; bus_if.im_ready = 1'b0;
      rand_fields();
      step(); step();
      reset = 1'b1;
      bus_if.im_ready = 1'b1;

      rand_fields();
      bus_if.fmt = 2'b00; bus_if.opcode = 6'd0; bus_if.rs = 5'd1; bus_if.rt = 5'd2;
      bus_if.rd = 5'd3; bus_if.shamt = 5'd0; bus_if.funct = 6'h21;
      send_one(); step(); step();

      clear = 1'b1; bus_if.in_valid = 1'b1; step(); bus_if.in_valid = 1'b0; clear = 1'b0;
      rand_fields();
      bus_if.fmt = 2'b01; bus_if.opcode = 6'h0d; bus_if.rs = 5'd0; bus_if.rt = 5'd1;
      bus_if.immediate = 16'h1234;
      send_one(); step();
      rand_fields();
      bus_if.fmt = 2'b10; bus_if.opcode = 6'd2; bus_if.instr_index = 26'h0000C03;
      send_one(); step();

      // Stalled write: outputs must hold while further bundles wait.
      bus_if.im_ready = 1'b0;
      rand_fields(); send_one();
      bus_if.in_valid = 1'b1;
      repeat (5) step();
      bus_if.in_valid = 1'b0;
      bus_if.im_ready = 1'b1; step();

      rand_fields(); bus_if.fmt = 2'b11; send_one();
      rand_fields(); send_one(); step();
      rand_fields(); bus_if.in_valid = 1'b1; repeat (3) step(); bus_if.in_valid = 1'b0;
      clear = 1'b1; step(); clear = 1'b0;
      rand_fields(); send_one(); step();

      // Abandon in-flight writes via clear, then via reset.
      bus_if.im_ready = 1'b0;
      rand_fields(); send_one(); step();
      clear = 1'b1; step(); clear = 1'b0; step();
      rand_fields(); send_one(); step();
      reset = 1'b0; step(); reset = 1'b1; step();

      for (int i = 0; i < 400; i++) begin
         rand_fields();
         if ($urandom_range(0, 7) == 0) bus_if.fmt = 2'b11;
         bus_if.in_valid = ($urandom_range(0, 3) != 0);
         bus_if.im_ready = ($urandom_range(0, 2) != 0);
         clear = ($urandom_range(0, 39) == 0);
         reset = ($urandom_range(0, 79) != 0);
         step();
      end

      reset = 1'b1; clear = 1'b0; bus_if.in_valid = 1'b0; bus_if.im_ready = 1'b1;
      repeat (3) step();
      @(negedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/instr_packer.md
Name: instr_packer

Overview:
- Encoder side of the instruction field interface: accepts decoded MIPS fields (format, opcode, rs, rt, rd, shamt, funct, immediate, instr_index) over a valid/ready handshake.
- Packs them into a 32-bit instruction word.
- Writes the word sequentially into instruction memory through a write port with backpressure.
- Used by the bench/boot loader to build IM contents. Its output word round-trips through the field splitter unchanged.

Parameters:
- DEPTH, 1024, number of instruction words the target IM holds; write counter saturates here.
- CNT_W, 11, width of the word counter; must hold 0..DEPTH.
- BASE_ADDR, 32'h00003000, byte address of IM word 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- clear  input  1  synchronous restart: counter to 0, full/err cleared.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- fmt  input  2  00=R, 01=I, 10=J, 11=illegal.
- opcode  input  6  instr[31:26].
- funct  input  6  instr[5:0] (R only).
- shamt  input  5  instr[10:6] (R only).
- rs  input  5  instr[25:21] (R, I).
- rt  input  5  instr[20:16] (R, I).
- rd  input  5  instr[15:11] (R only).
- immediate  input  16  instr[15:0] (I only).
- instr_index  input  26  instr[25:0] (J only).
- im_we  output  1  write request to IM.
- im_ready  input  1  IM accepts write this cycle.
- im_addr  output  32  byte address = BASE_ADDR + 4*count.
- im_wdata  output  32  packed instruction.
- count  output  CNT_W  words written so far.
- full  output  1  count == DEPTH.
- err  output  1  sticky: illegal fmt seen.

Behaviour:
- Reset (reset=0 at clk edge) values: im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, full=0, err=0, state=IDLE. Reset applies mid-write; a pending word is discarded.
- Packing:
  - R: {opcode, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, immediate}.
  - J: {opcode, instr_index}.
  - Unused fields are ignored.
- FSM states: IDLE, WRITE, FULL.
- in_ready = (state==IDLE) && !clear.
- A transfer happens when in_valid && in_ready at a clk edge.
- IDLE:
  - Transfer with fmt!=11: latch packed word into im_wdata, im_addr = BASE_ADDR + 4*count, im_we=1, go to WRITE. im_we is asserted the cycle after acceptance (latency 1).
  - Transfer with fmt==11: bundle consumed and dropped, err<=1, stay IDLE, count unchanged.
- WRITE:
  - im_we, im_addr and im_wdata are held stable until im_ready=1 at a clk edge.
  - On that edge: im_we<=0 and count<=count+1.
  - Next state is FULL if the new count==DEPTH, else IDLE.
  - Back-to-back rate: one word per 2 cycles when im_ready is tied high.
- FULL: full=1, in_ready=0, no writes. Left only via clear or reset.
- clear=1 at a clk edge, any state: count<=0, full<=0, err<=0, im_we<=0, state<=IDLE. An in-flight WRITE is abandoned. in_ready=0 during the clear cycle, so a simultaneous in_valid is not consumed.
- reset has priority over clear.
- count never wraps; it saturates at DEPTH via the FULL state.
- err stays 1 across further legal writes until clear or reset.

Test Plan:
- After reset, R bundle op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x21 -> next cycle im_we=1, im_wdata=0x00221821, im_addr=0x00003000. With im_ready=1, count=1.
- I bundle op=0x0d, rs=0, rt=1, imm=0x1234, then J bundle op=2, index=0x0000C03 ->
  - im_wdata=0x34011234 at 0x00003000.
  - im_wdata=0x08000C03 at 0x00003004.
  - count=2.
- im_ready held 0 for 5 cycles during WRITE -> im_we, im_addr and im_wdata stable all 5 cycles, in_ready=0, count unchanged. Write completes on the first im_ready=1 edge.
- fmt=11 with in_valid -> no im_we, err=1, count unchanged. A following legal bundle writes normally and err stays 1.
- DEPTH=4 build: write 4 words -> full=1, in_ready=0, a fifth in_valid is ignored. clear -> count=0, full=0, next write goes to 0x00003000.
- clear or reset asserted while im_we=1 and im_ready=0 -> next cycle im_we=0, count=0, state IDLE, in_ready=1.
